apb_cpu_subsystem: RTL and testbench
====================================

Name: apb_cpu_subsystem

Overview:
- Minimal 32-bit instruction-driven CPU that executes from an internal instruction memory.
- Acts as APB master to two register-file slaves (slave 0, slave 1).
- Includes a watchdog timer.
- Top-level block of the processor/APB subsystem; the bench preloads instruction memory by hierarchical backdoor write to cpu1.imemory.mem[] and then raises run.

Parameters:
- IMEM_DEPTH, 256, instruction memory words (32-bit each); PC width = log2(IMEM_DEPTH).
- SLV_REGS, 16, 32-bit registers per APB slave.
- WDT_TIMEOUT, 1024, watchdog expiry count in clk cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  CPU execute enable.
- prdata_0  output  32  data of last completed APB read from slave 0.
- prdata_1  output  32  data of last completed APB read from slave 1.
- wdt_trigger_reset  output  1  one-cycle watchdog expiry pulse.
- cpudone  output  1  program finished (sticky until reset).
- Interface: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Hierarchy is fixed for backdoor load: CPU instance cpu1, memory instance imemory, array mem[0:IMEM_DEPTH-1] of 32 bits.
- reset does not clear mem.
- Instruction word: [31:29] opcode, [28:16] addr (13b), [15:0] data.
- Slave select = addr[12]; register index = addr[3:0].
- Reset values: pc=0, FSM=FETCH, prdata_0=prdata_1=0, cpudone=0, wdt_trigger_reset=0, all slave registers 0, watchdog counter 0.
- CPU FSM states: FETCH, EXEC, APB_SETUP, APB_ACCESS, IMEM_WR, DONE.
- FETCH: if run=1, latch mem[pc] into IR and go to EXEC; if run=0, hold in FETCH.
- EXEC, by opcode:
  - 000 NOP: pc+1, go to FETCH.
  - 001 APB_WR: pwdata={16'b0,data}, pwrite=1, go to APB_SETUP.
  - 010 APB_RD: pwrite=0, go to APB_SETUP.
  - 011 IMEM_WR: go to IMEM_WR.
  - 100 WDT_KICK: clear watchdog counter, pc+1, go to FETCH.
  - 111 HALT: go to DONE.
  - 101, 110: treated as NOP.
- APB transfer:
  - APB_SETUP: psel=1, penable=0.
  - APB_ACCESS: psel=1, penable=1; pready is always 1 (zero wait states).
  - Transfer completes at the end of ACCESS. A write updates reg[addr[3:0]] of the selected slave. A read loads prdata_N of the selected slave; the other prdata output is unchanged.
  - Then pc+1, go to FETCH.
- IMEM_WR: mem[addr[7:0]] <= mem[pc+1]; pc += 2; go to FETCH.
- Latency: NOP and WDT_KICK take 2 cycles; APB_WR and APB_RD take 4 cycles; IMEM_WR takes 3 cycles.
- run deasserted mid-instruction: the current instruction, including any APB transfer, completes; the CPU then stalls in FETCH.
- pc wrap: if pc+1 (or pc+2) exceeds IMEM_DEPTH-1, go to DONE instead of wrapping.
- IMEM_WR at the last word (no following data word) goes to DONE with no write.
- DONE: cpudone=1; pc frozen; APB idle; only reset exits.
- Watchdog:
  - Increments each cycle while run=1 and cpudone=0.
  - When the counter reaches WDT_TIMEOUT-1: wdt_trigger_reset=1 for exactly one cycle, counter reloads to 0.
  - A kick in the same cycle as expiry wins: counter cleared, no pulse.
  - The pulse does not reset the CPU; it is an output only.

Optional Feature:
- WDT_EN defined: watchdog is present as described above.
- WDT_EN undefined: no watchdog logic; wdt_trigger_reset tied 0; opcode 100 behaves as NOP.

Test Plan:
- Reset, all-zero imem, run=1 -> NOPs to the end of memory; cpudone=1 after 2*256 cycles; prdata_0=prdata_1=0.
- mem[0]={001,13'h0003,16'hABCD}, mem[1]={010,13'h0003,0}, mem[2]={111,0,0} -> prdata_0=32'h0000ABCD 8 cycles after run; then cpudone=1; prdata_1 stays 0.
- Write 16'h1234 to addr 13'h1005, then read it back -> prdata_1=32'h00001234, prdata_0 unchanged.
- mem[0]={011,13'h0010,0}, mem[1]=32'hE0000000 (HALT), mem[2]=NOP…, then execution reaches 0x10 -> mem[16]=32'hE0000000; CPU halts at pc=16.
- WDT_TIMEOUT=16, program of NOPs without kick -> wdt_trigger_reset is a one-cycle pulse every 16 cycles; with a kick every 4 instructions -> never asserts.
- run dropped during APB_SETUP of a write -> write completes, CPU stalls in FETCH; run raised again -> execution resumes at the next pc.
- Reset asserted mid-program -> all outputs 0 the next cycle; imem contents retained.

Source files
------------

// File: rtl/apb_cpu_subsystem.sv
// Minimal CPU executing from internal instruction memory, APB master to two register-file slaves.
// Define WDT_EN to include the watchdog; otherwise wdt_trigger_reset is tied low and opcode 100 is a NOP.

module apb_cpu_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] waddr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata_a,
  output logic [31:0]   rdata_b
);
  logic [31:0] mem [0:DEPTH-1];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

module apb_cpu_slave #(
  parameter int SLV_REGS = 16,
  parameter int RIDX_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [RIDX_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready
);
  logic [31:0] regs [0:SLV_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLV_REGS; i++) regs[i] <= '0;
    end else if (psel && penable && pwrite) begin
      regs[paddr] <= pwdata;
    end
  end

  assign prdata = regs[paddr];
  assign pready = 1'b1;
endmodule

module apb_cpu #(
  parameter int IMEM_DEPTH  = 256,
  parameter int WDT_TIMEOUT = 1024,
  parameter int RIDX_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              psel_0,
  output logic              psel_1,
  output logic              penable,
  output logic              pwrite,
  output logic [RIDX_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata_s0,
  input  logic [31:0]       prdata_s1,
  input  logic              pready,
  output logic [31:0]       prdata_0,
  output logic [31:0]       prdata_1,
  output logic              wdt_trigger_reset,
  output logic              cpudone
);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam logic [PC_W:0] PC_LAST = (PC_W+1)'(IMEM_DEPTH - 1);
  localparam logic [2:0] OP_APB_WR  = 3'b001;
  localparam logic [2:0] OP_APB_RD  = 3'b010;
  localparam logic [2:0] OP_IMEM_WR = 3'b011;
  localparam logic [2:0] OP_HALT    = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_APB_SETUP, S_APB_ACCESS, S_IMEM_WR, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W:0]   pc_inc1, pc_inc2;
  logic [31:0]     ir, imem_rdata, imem_next;
  logic [2:0]      opcode;
  logic            ir_ld, adv, mem_we, rd_done;
  logic            unused_ir;

  assign opcode    = ir[31:29];
  assign pc_inc1   = {1'b0, pc} + (PC_W+1)'(1);
  assign pc_inc2   = {1'b0, pc} + (PC_W+1)'(2);
  assign unused_ir = ^ir[27:16];

  apb_cpu_imem #(.DEPTH(IMEM_DEPTH), .AW(PC_W)) imemory (
    .clk     (clk),
    .raddr_a (pc),
    .raddr_b (pc_inc1[PC_W-1:0]),
    .waddr   (ir[16 +: PC_W]),
    .we      (mem_we && !reset),
    .wdata   (imem_next),
    .rdata_a (imem_rdata),
    .rdata_b (imem_next)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_ld     = 1'b0;
    adv       = 1'b0;
    mem_we    = 1'b0;
    case (state)
      S_FETCH: begin
        if (run) begin
          ir_ld     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_APB_WR, OP_APB_RD: state_nxt = S_APB_SETUP;
          OP_IMEM_WR:           state_nxt = (pc_inc1 > PC_LAST) ? S_DONE : S_IMEM_WR;
          OP_HALT:              state_nxt = S_DONE;
          default:              adv = 1'b1;
        endcase
      end
      S_APB_SETUP:  state_nxt = S_APB_ACCESS;
      S_APB_ACCESS: adv = pready;
      S_IMEM_WR: begin
        mem_we = 1'b1;
        if (pc_inc2 > PC_LAST) begin
          state_nxt = S_DONE;
        end else begin
          pc_nxt    = pc_inc2[PC_W-1:0];
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_DONE;
    endcase
    // Running off the end of memory halts instead of wrapping.
    if (adv) begin
      if (pc_inc1 > PC_LAST) begin
        state_nxt = S_DONE;
      end else begin
        pc_nxt    = pc_inc1[PC_W-1:0];
        state_nxt = S_FETCH;
      end
    end
  end

  assign rd_done = (state == S_APB_ACCESS) && pready && (opcode == OP_APB_RD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      prdata_0 <= '0;
      prdata_1 <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (rd_done && !ir[28]) prdata_0 <= prdata_s0;
      if (rd_done &&  ir[28]) prdata_1 <= prdata_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (ir_ld) ir <= imem_rdata;
  end

  assign psel_0  = ((state == S_APB_SETUP) || (state == S_APB_ACCESS)) && !ir[28];
  assign psel_1  = ((state == S_APB_SETUP) || (state == S_APB_ACCESS)) &&  ir[28];
  assign penable = (state == S_APB_ACCESS);
  assign pwrite  = (opcode == OP_APB_WR);
  assign paddr   = ir[16 +: RIDX_W];
  assign pwdata  = {16'h0000, ir[15:0]};
  assign cpudone = (state == S_DONE);

`ifdef WDT_EN
  localparam int CNT_W = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
  localparam logic [2:0] OP_WDT_KICK = 3'b100;
  logic [CNT_W-1:0] wdt_cnt;
  logic             kick;

  assign kick = (state == S_EXEC) && (opcode == OP_WDT_KICK);

  // A kick in the expiry cycle takes priority and suppresses the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt           <= '0;
      wdt_trigger_reset <= 1'b0;
    end else begin
      wdt_trigger_reset <= 1'b0;
      if (kick) begin
        wdt_cnt <= '0;
      end else if (run && (state != S_DONE)) begin
        if (wdt_cnt == CNT_W'(WDT_TIMEOUT - 1)) begin
          wdt_cnt           <= '0;
          wdt_trigger_reset <= 1'b1;
        end else begin
          wdt_cnt <= wdt_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign wdt_trigger_reset = 1'b0;
`endif
endmodule

module apb_cpu_subsystem #(
  parameter int IMEM_DEPTH  = 256,
  parameter int SLV_REGS    = 16,
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] prdata_0,
  output logic [31:0] prdata_1,
  output logic        wdt_trigger_reset,
  output logic        cpudone
);
  localparam int RIDX_W = $clog2(SLV_REGS);

  logic              psel_0, psel_1, penable, pwrite, pready, pready_0, pready_1;
  logic [RIDX_W-1:0] paddr;
  logic [31:0]       pwdata, prdata_s0, prdata_s1;

  assign pready = psel_1 ? pready_1 : pready_0;

  apb_cpu #(.IMEM_DEPTH(IMEM_DEPTH), .WDT_TIMEOUT(WDT_TIMEOUT), .RIDX_W(RIDX_W)) cpu1 (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .psel_0            (psel_0),
    .psel_1            (psel_1),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .prdata_s0         (prdata_s0),
    .prdata_s1         (prdata_s1),
    .pready            (pready),
    .prdata_0          (prdata_0),
    .prdata_1          (prdata_1),
    .wdt_trigger_reset (wdt_trigger_reset),
    .cpudone           (cpudone)
  );

  apb_cpu_slave #(.SLV_REGS(SLV_REGS), .RIDX_W(RIDX_W)) slv0 (
    .clk (clk), .reset (reset), .psel (psel_0), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .prdata (prdata_s0), .pready (pready_0)
  );

  apb_cpu_slave #(.SLV_REGS(SLV_REGS), .RIDX_W(RIDX_W)) slv1 (
    .clk (clk), .reset (reset), .psel (psel_1), .penable (penable), .pwrite (pwrite),
    .paddr (paddr), .pwdata (pwdata), .prdata (prdata_s1), .pready (pready_1)
  );
endmodule

// File: tb/tb_apb_cpu_subsystem.sv
// Scoreboard bench for apb_cpu_subsystem: an instruction-level reference model predicts output
// events per cycle; a monitor process pops and compares them as the DUT runs.
`timescale 1ns/1ps
module tb_apb_cpu_subsystem;
  localparam int DEPTH = 256;
  localparam int NREG  = 16;
  localparam int WDT_T = 16;
  localparam int MAXC  = 2048;
`ifdef WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] prdata_0, prdata_1;
  logic        wdt_trigger_reset, cpudone;

  apb_cpu_subsystem #(.IMEM_DEPTH(DEPTH), .SLV_REGS(NREG), .WDT_TIMEOUT(WDT_T)) dut (
    .clk               (clk),
    .reset             (reset),
    .run               (run),
    .prdata_0          (prdata_0),
    .prdata_1          (prdata_1),
    .wdt_trigger_reset (wdt_trigger_reset),
    .cpudone           (cpudone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          full;
    logic [31:0] p0;
    logic [31:0] p1;
    logic        done;
  } ev_t;

  ev_t         exp_q[$];
  int          wdt_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] s_reg [2][NREG];
  bit          run_sched [MAXC+2];
  bit          kick_at [MAXC+2];
  int          cyc = 0;
  bit          active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= active ? cyc + 1 : 0;

  // Monitor: compares every predicted event at its cycle, and the watchdog output every cycle.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  exp_w;
    if (active && cyc > 0) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.full) begin
          chk("prdata_0", prdata_0, e.p0);
          chk("prdata_1", prdata_1, e.p1);
        end
        chk("cpudone", {31'b0, cpudone}, {31'b0, e.done});
      end
      exp_w = (wdt_q.size() > 0 && wdt_q[0] == cyc);
      if (exp_w) void'(wdt_q.pop_front());
      chk("wdt_trigger_reset", {31'b0, wdt_trigger_reset}, {31'b0, exp_w});
    end
  end

  // Instruction-level reference model: walks the program, accumulating cycle time per instruction.
  task automatic model(input int ncyc);
    logic [31:0] p0, p1, ir;
    logic [2:0]  op;
    logic [12:0] a;
    int          pc, t, done_cyc, c, len, npc;
    bit          halt;
    p0 = '0; p1 = '0; pc = 0; t = 1; done_cyc = 0; c = 0;
    exp_q.delete();
    wdt_q.delete();
    for (int k = 0; k < MAXC + 2; k++) kick_at[k] = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < NREG; r++) s_reg[s][r] = '0;
    while (t <= ncyc) begin
      if (!run_sched[t]) begin
        t++;
        continue;
      end
      ir = m_mem[pc]; op = ir[31:29]; a = ir[28:16];
      halt = 1'b0; npc = pc + 1; len = 2;
      case (op)
        3'd1, 3'd2: len = 4;
        3'd3: if (pc != DEPTH - 1) begin len = 3; npc = pc + 2; end
        3'd7: halt = 1'b1;
        default: ;
      endcase
      if (npc > DEPTH - 1) halt = 1'b1;
      if (t + len - 1 > ncyc) break;
      if (halt) exp_q.push_back('{t + len - 2, 1'b0, 32'h0, 32'h0, 1'b0});
      if (WDT_ON && op == 3'd4) kick_at[t + 1] = 1'b1;
      case (op)
        3'd1: begin
          s_reg[a[12]][a[3:0]] = {16'h0, ir[15:0]};
          exp_q.push_back('{t + len - 1, 1'b1, p0, p1, 1'b0});
        end
        3'd2: begin
          if (a[12]) p1 = s_reg[1][a[3:0]];
          else       p0 = s_reg[0][a[3:0]];
          exp_q.push_back('{t + len - 1, 1'b1, p0, p1, 1'b0});
        end
        3'd3: if (len == 3) m_mem[a[7:0]] = m_mem[pc + 1];
        default: ;
      endcase
      if (halt) begin
        done_cyc = t + len - 1;
        exp_q.push_back('{done_cyc, 1'b1, p0, p1, 1'b1});
        break;
      end
      pc = npc;
      t  = t + len;
    end
    if (done_cyc == 0) exp_q.push_back('{ncyc, 1'b1, p0, p1, 1'b0});
    if (WDT_ON) begin
      for (int k = 1; k <= ncyc; k++) begin
        if (kick_at[k]) c = 0;
        else if (run_sched[k] && !(done_cyc != 0 && done_cyc < k)) begin
          if (c == WDT_T - 1) begin
            c = 0;
            wdt_q.push_back(k);
          end else c++;
        end
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    for (int k = 0; k < MAXC + 2; k++) run_sched[k] = 1'b1;
  endtask

  task automatic gen_random(input bit rand_run);
    int          r;
    logic [2:0]  op;
    logic [12:0] a;
    logic [15:0] d;
    clear_prog();
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 20) op = 3'd1;
      else if (r < 40) op = 3'd2;
      else if (r < 50) op = 3'd3;
      else if (r < 62) op = 3'd4;
      else if (r < 63) op = 3'd7;
      else if (r < 70) op = 3'($urandom_range(5, 6));
      else             op = 3'd0;
      a = 13'($urandom);
      d = 16'($urandom);
      m_mem[i] = {op, a, d};
    end
    if (rand_run)
      for (int k = 0; k < MAXC + 2; k++) run_sched[k] = ($urandom_range(0, 9) != 0);
  endtask

  task automatic run_test(input int ncyc);
    int bad;
    for (int i = 0; i < DEPTH; i++) dut.cpu1.imemory.mem[i] <= m_mem[i];
    model(ncyc);
    @(negedge clk);
    reset = 1'b0;
    run = run_sched[1];
    active = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #2;
      run = (k < ncyc) ? run_sched[k + 1] : 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #1 active = 1'b0;
    @(negedge clk);
    chk("reset prdata_0", prdata_0, 32'h0);
    chk("reset prdata_1", prdata_1, 32'h0);
    chk("reset cpudone", {31'b0, cpudone}, 32'h0);
    chk("reset wdt_trigger_reset", {31'b0, wdt_trigger_reset}, 32'h0);
    chk("pending events", exp_q.size(), 0);
    chk("pending wdt pulses", wdt_q.size(), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dut.cpu1.imemory.mem[i] !== m_mem[i]) bad++;
    chk("imem words differing", bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("init prdata_0", prdata_0, 32'h0);
    chk("init prdata_1", prdata_1, 32'h0);
    chk("init cpudone", {31'b0, cpudone}, 32'h0);
    chk("init wdt_trigger_reset", {31'b0, wdt_trigger_reset}, 32'h0);

    // All-NOP memory runs off the end and halts.
    clear_prog();
    run_test(530);

    // Write then read back slave 0.
    clear_prog();
    m_mem[0] = {3'b001, 13'h0003, 16'hABCD};
    m_mem[1] = {3'b010, 13'h0003, 16'h0000};
    m_mem[2] = 32'hE000_0000;
    run_test(20);

    // Slave 1 access leaves prdata_0 untouched.
    clear_prog();
    m_mem[0] = {3'b001, 13'h0003, 16'hABCD};
    m_mem[1] = {3'b010, 13'h0003, 16'h0000};
    m_mem[2] = {3'b001, 13'h1005, 16'h1234};
    m_mem[3] = {3'b010, 13'h1005, 16'h0000};
    m_mem[4] = 32'hE000_0000;
    run_test(30);

    // Self-modifying copy plants a HALT at word 16.
    clear_prog();
    m_mem[0] = {3'b011, 13'h0010, 16'h0000};
    m_mem[1] = 32'hE000_0000;
    run_test(60);

    // Regular kicks.
    clear_prog();
    for (int i = 0; i < 200; i++) m_mem[i] = (i % 4 == 3) ? 32'h8000_0000 : 32'h0;
    m_mem[200] = 32'hE000_0000;
    run_test(410);

    // run dropped during the write's setup phase, raised again later.
    clear_prog();
    m_mem[0] = {3'b001, 13'h1002, 16'h5555};
    m_mem[1] = {3'b010, 13'h1002, 16'h0000};
    m_mem[2] = 32'hE000_0000;
    for (int k = 3; k <= 10; k++) run_sched[k] = 1'b0;
    run_test(30);

    // IMEM_WR in the last word: no data word, halts without writing.
    clear_prog();
    m_mem[100] = {3'b001, 13'h1007, 16'hBEEF};
    m_mem[101] = {3'b010, 13'h1007, 16'h0000};
    m_mem[255] = {3'b011, 13'h0005, 16'h0000};
    run_test(530);

    // IMEM_WR in the second-last word: copies, then halts.
    clear_prog();
    m_mem[254] = {3'b011, 13'h0007, 16'h0000};
    m_mem[255] = 32'h1234_5678;
    run_test(530);

    // Random programs with random run gaps; the last one is cut short by reset.
    for (int it = 0; it < 3; it++) begin
      gen_random(1'b1);
      run_test(600);
    end
    gen_random(1'b0);
    run_test(150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
